// File: rtl/instr_fetch_responder_if.sv
// Fetch-side request/response bus plus the backing-memory read channel.
// The responder takes the slave view; the fetch stage / memory model takes the master view.
interface instr_fetch_responder_if;
  // fetch request
  logic        req_valid;
  logic [15:0] req_addr;
  logic        req_ready;
  logic        flush;
  // fetch response
  logic        resp_valid;
  logic [15:0] resp_instr;
  logic        busy;
  // backing-memory read channel
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output req_valid, req_addr, flush, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_instr, busy, mem_req, mem_addr
  );

  modport slave (
    input  req_valid, req_addr, flush, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_instr, busy, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: direct-mapped cache of 16-bit words, one per line.
// Hits answer one cycle after acceptance; misses fetch the word from backing
// memory over a req/ack handshake and hold off further requests via busy.
module instr_fetch_responder #(
  parameter  int LINES = 4,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_fetch_responder_if.slave   bus
);

  localparam int TAG_W = 15 - IDX_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MISS = 1'b1
  } state_t;

  // Control / response state (reset)
  state_t              state_q,      state_d;
  logic [LINES-1:0]    valid_q,      valid_d;
  logic                flush_pend_q, flush_pend_d;
  logic                resp_valid_q, resp_valid_d;
  logic [15:0]         resp_instr_q, resp_instr_d;
  logic [15:0]         mem_addr_q,   mem_addr_d;

  // Line storage (not reset; guarded by valid_q)
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [15:0]         data_q [LINES];

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic                ready;
  logic                accept;
  logic                hit;
  logic                fill_en;

  assign req_idx  = bus.req_addr[IDX_W:1];
  assign req_tag  = bus.req_addr[15:IDX_W+1];
  assign fill_idx = mem_addr_q[IDX_W:1];
  assign fill_tag = mem_addr_q[15:IDX_W+1];

  // Requests are taken only in IDLE and never while reset is asserted.
  assign ready  = (state_q == S_IDLE) && rst;
  assign accept = bus.req_valid && ready;
  // A flush in the accepting cycle turns every lookup into a miss.
  assign hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !bus.flush;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_instr = resp_instr_q;
  assign bus.busy       = (state_q == S_MISS);
  assign bus.mem_req    = (state_q == S_MISS);
  assign bus.mem_addr   = mem_addr_q;

  // Next-state logic: lookup, miss launch, fill completion and flush handling.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    resp_valid_d = 1'b0;
    resp_instr_d = resp_instr_q;
    mem_addr_d   = mem_addr_q;
    fill_en      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hit) begin
            resp_valid_d = 1'b1;
            resp_instr_d = data_q[req_idx];
          end else begin
            mem_addr_d = {bus.req_addr[15:1], 1'b0};
            state_d    = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (bus.flush) flush_pend_d = 1'b1;
        if (bus.mem_ack) begin
          // A flush seen at any point during this miss keeps the stale word out of the cache.
          fill_en      = !flush_pend_q && !bus.flush;
          resp_valid_d = 1'b1;
          resp_instr_d = bus.mem_rdata;
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush)    valid_d           = '0;
    else if (fill_en) valid_d[fill_idx] = 1'b1;
  end

  // Control state register with synchronous active-low reset; abandons any open miss.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Line install on a completed, un-flushed fill.
  always_ff @(posedge clk) begin
    // NOTE: tag/data arrays are deliberately left without reset; valid_q alone qualifies them.
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.mem_rdata;
    end
  end

endmodule

// File: doc/instr_fetch_responder.md
# instr_fetch_responder

- Memory-side responder for the fetch stage: accepts one fetch request per cycle and returns the 16-bit instruction at that address.
- Hits are served from a small direct-mapped instruction cache.
- Misses are filled from backing memory over a req/ack handshake.
- While a miss is outstanding, `busy` is high; it feeds the fetch stage's PC-hold (hazard) input.

## Interface
Parameters:
- `LINES`, default 4: number of cache lines, one 16-bit word per line, power of two, ≥2.
- `IDX_W`, default $clog2(LINES): index width, derived, not overridden.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `req_valid` in 1: fetch request present.
- `req_addr` in 16: byte address; bit 0 ignored.
- `req_ready` out 1: request accepted this cycle when `req_valid & req_ready`.
- `flush` in 1: invalidate all lines.
- `resp_valid` out 1: `resp_instr` valid this cycle; one-cycle pulse per request.
- `resp_instr` out 16: returned instruction.
- `busy` out 1: high while in MISS.
- `mem_req` out 1: backing-memory read request.
- `mem_addr` out 16: backing-memory byte address, bit 0 forced 0.
- `mem_ack` in 1: `mem_rdata` valid, read complete.
- `mem_rdata` in 16: backing-memory read data.

## Operation
- Address split:
  - index = `req_addr[IDX_W:1]`
  - tag = `req_addr[15:IDX_W+1]`
- Storage per line: valid bit, tag, 16-bit data.
- FSM state IDLE:
  - `req_ready`=1, `busy`=0.
  - On accept, tag/valid lookup is combinational on `req_addr`.
  - Hit: line data is registered to `resp_instr`, `resp_valid`=1 next cycle, state stays IDLE.
  - Miss: `req_addr` with bit 0 cleared is latched into `mem_addr`; state goes to MISS.
- FSM state MISS:
  - `req_ready`=0, `busy`=1, `mem_req`=1, `mem_addr` stable.
  - On the edge where `mem_ack`=1:
    - line[index] ← {valid=1, tag, `mem_rdata`}, unless `flush_pend` is set.
    - `resp_instr` ← `mem_rdata`, `resp_valid`=1 next cycle.
    - state goes to IDLE and `flush_pend` clears.
- `mem_ack` while not in MISS: ignored.
- Flush:
  - IDLE: all valid bits cleared at the edge. A request accepted in the same cycle is treated as a miss regardless of stored state.
  - MISS: all valid bits cleared and `flush_pend` set. The outstanding fill still returns its response but does not install the line.
- Reset (`rst`=0 at an edge), including mid-MISS:
  - state IDLE, all valid bits 0, `flush_pend` 0.
  - `resp_valid` 0, `resp_instr` 16'h0000, `mem_req` 0, `mem_addr` 16'h0000, `busy` 0.
  - An outstanding miss is abandoned; no response is issued for it.
- `req_ready` is forced 0 while `rst`=0.
- Tag/data arrays need no reset; only valid bits are reset.

## Timing
- Hit latency: 1 cycle (accept at edge T → `resp_valid` high in cycle T+1).
- Back-to-back hits sustain one response per cycle.
- Miss:
  - `mem_req` rises in cycle T+1 and stays high through the ack cycle A inclusive.
  - `mem_req`=0 and `resp_valid`=1 in cycle A+1.
  - `req_ready`=1 again in cycle A+1.
  - Minimum miss latency is 2 cycles (ack in T+1).
- `resp_valid` is never high two cycles for one request.
- Responses are returned in request order.
- `resp_instr` holds its last value when `resp_valid`=0.
- A hit accepted in cycle A+1 responds in A+2.
- The line filled at A is visible to a lookup in A+1.

## Test plan
- Reset then cold fetch:
  - Stimulus: `rst`=0 for 2 cycles, then request 0x0000; `mem_ack` 3 cycles after `mem_req` with `mem_rdata`=0xA123.
  - Required: `mem_addr`=0x0000, `busy`=1 for 3 cycles, one `resp_valid` pulse with 0xA123.
  - Required: re-fetch of 0x0000 hits with 1-cycle latency and `mem_req` stays 0.
- Streaming hits:
  - Stimulus: preload 0x0000/2/4/6 via misses, then request all four on consecutive cycles.
  - Required: 4 consecutive `resp_valid` cycles in order, `req_ready` constantly 1.
- Conflict eviction (LINES=4):
  - Stimulus: fetch 0x0002 (data 0x1111), then 0x000A (same index, data 0x2222), then 0x0002 again.
  - Required: the third request misses and `mem_addr`=0x0002.
  - Odd address 0x0003 hits the same line as 0x0002.
- Flush:
  - Flush in IDLE after warming 0x0004: next fetch of 0x0004 misses.
  - Flush asserted in the middle of a miss on 0x0008: response still returned, then 0x0008 misses again.
- Reset mid-miss:
  - Stimulus: `rst`=0 while `mem_req`=1, then `mem_ack`=1 arriving after reset.
  - Required: next cycle `mem_req`=0, `busy`=0, no `resp_valid`; the late ack produces nothing.
- Spurious ack:
  - Stimulus: `mem_ack`=1 in IDLE with 0xDEAD.
  - Required: no response, no line install; a subsequent fetch still misses.
